// File: rtl/br_train.sv
// Branch-resolution training queue: buffers resolved branches/jumps in order and,
// on retirement, emits registered BTB training strobes plus a mispredict redirect.
module br_train #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            res_valid_,
    input  logic            res_jump_,
    input  logic            res_taken_,
    input  logic            res_pred_taken_,
    input  logic [ADDR-1:0] res_pc,
    input  logic [ADDR-1:0] res_target,
    input  logic [ADDR-1:0] res_pred_target,
    output logic            res_full,
    input  logic            commit_,
    input  logic            flush_,
    output logic            br_commit_,
    output logic            br_taken_,
    output logic            br_miss_,
    output logic            jump_commit_,
    output logic            jump_miss_,
    output logic [ADDR-1:0] com_addr,
    output logic [ADDR-1:0] com_tar_addr,
    output logic            redirect_,
    output logic [ADDR-1:0] redirect_addr,
    output logic            underflow,
    output logic [CNTW-1:0] miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // Queue storage, flags kept active-high internally
    logic            jump_mem_r   [DEPTH];
    logic            taken_mem_r  [DEPTH];
    logic            pt_mem_r     [DEPTH];
    logic [ADDR-1:0] pc_mem_r     [DEPTH];
    logic [ADDR-1:0] tgt_mem_r    [DEPTH];
    logic [ADDR-1:0] ptgt_mem_r   [DEPTH];

    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;

    logic            empty_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;

    logic            head_jump_s;
    logic            head_taken_s;
    logic            head_pt_s;
    logic [ADDR-1:0] head_pc_s;
    logic [ADDR-1:0] head_tgt_s;
    logic [ADDR-1:0] head_ptgt_s;

    logic            miss_s;
    logic            nxt_br_commit_s;
    logic            nxt_br_taken_s;
    logic            nxt_br_miss_s;
    logic            nxt_jump_commit_s;
    logic            nxt_jump_miss_s;
    logic [ADDR-1:0] nxt_com_addr_s;
    logic [ADDR-1:0] nxt_com_tar_s;
    logic            nxt_redirect_s;
    logic [ADDR-1:0] nxt_redirect_addr_s;

    assign empty_s = (count_r == '0);
    assign full_s  = (count_r == FULL_CNT);
    assign pop_s   = !commit_ && !empty_s;
    // A flush discards any incoming entry; a full queue only accepts alongside a pop
    assign push_s  = !res_valid_ && flush_ && (!full_s || pop_s);

    assign head_jump_s  = jump_mem_r[rd_ptr_r];
    assign head_taken_s = taken_mem_r[rd_ptr_r];
    assign head_pt_s    = pt_mem_r[rd_ptr_r];
    assign head_pc_s    = pc_mem_r[rd_ptr_r];
    assign head_tgt_s   = tgt_mem_r[rd_ptr_r];
    assign head_ptgt_s  = ptgt_mem_r[rd_ptr_r];

    // Entry storage write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                jump_mem_r[i]  <= 1'b0;
                taken_mem_r[i] <= 1'b0;
                pt_mem_r[i]    <= 1'b0;
                pc_mem_r[i]    <= '0;
                tgt_mem_r[i]   <= '0;
                ptgt_mem_r[i]  <= '0;
            end
        end else if (push_s) begin
            jump_mem_r[wr_ptr_r]  <= !res_jump_;
            taken_mem_r[wr_ptr_r] <= !res_taken_;
            pt_mem_r[wr_ptr_r]    <= !res_pred_taken_;
            pc_mem_r[wr_ptr_r]    <= res_pc;
            tgt_mem_r[wr_ptr_r]   <= res_target;
            ptgt_mem_r[wr_ptr_r]  <= res_pred_target;
        end
    end

    // Pointers and occupancy; flush wins over any push/pop bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (!flush_) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Training decode of the head entry being retired this cycle
    always_comb begin
        nxt_br_commit_s     = 1'b1;
        nxt_br_taken_s      = 1'b1;
        nxt_br_miss_s       = 1'b1;
        nxt_jump_commit_s   = 1'b1;
        nxt_jump_miss_s     = 1'b1;
        nxt_com_addr_s      = '0;
        nxt_com_tar_s       = '0;
        nxt_redirect_s      = 1'b1;
        nxt_redirect_addr_s = '0;
        miss_s              = 1'b0;
        if (pop_s) begin
            nxt_com_addr_s = head_pc_s;
            nxt_com_tar_s  = head_tgt_s;
            if (head_jump_s) begin
                nxt_jump_commit_s = 1'b0;
                miss_s            = !head_pt_s || (head_ptgt_s != head_tgt_s);
                nxt_jump_miss_s   = !miss_s;
            end else begin
                nxt_br_commit_s = 1'b0;
                nxt_br_taken_s  = !head_taken_s;
                miss_s          = (head_pt_s != head_taken_s) ||
                                  (head_taken_s && head_pt_s && (head_ptgt_s != head_tgt_s));
                nxt_br_miss_s   = !miss_s;
            end
            if (miss_s) begin
                nxt_redirect_s      = 1'b0;
                nxt_redirect_addr_s = (head_jump_s || head_taken_s) ? head_tgt_s
                                                                    : head_pc_s + ADDR'(32'd4);
            end else begin
                nxt_redirect_s = 1'b1;
            end
        end else begin
            miss_s = 1'b0;
        end
    end

    // Registered training/redirect outputs, idle unless a pop happened last edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_commit_    <= 1'b1;
            br_taken_     <= 1'b1;
            br_miss_      <= 1'b1;
            jump_commit_  <= 1'b1;
            jump_miss_    <= 1'b1;
            com_addr      <= '0;
            com_tar_addr  <= '0;
            redirect_     <= 1'b1;
            redirect_addr <= '0;
        end else begin
            br_commit_    <= nxt_br_commit_s;
            br_taken_     <= nxt_br_taken_s;
            br_miss_      <= nxt_br_miss_s;
            jump_commit_  <= nxt_jump_commit_s;
            jump_miss_    <= nxt_jump_miss_s;
            com_addr      <= nxt_com_addr_s;
            com_tar_addr  <= nxt_com_tar_s;
            redirect_     <= nxt_redirect_s;
            redirect_addr <= nxt_redirect_addr_s;
        end
    end

    // Full flag, sticky underflow and saturating miss counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_full  <= 1'b0;
            underflow <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            if (!flush_) begin
                res_full <= 1'b0;
            end else begin
                case ({push_s, pop_s})
                    2'b10:   res_full <= (count_r == FULL_CNT - (PW+1)'(1));
                    2'b01:   res_full <= 1'b0;
                    default: res_full <= full_s;
                endcase
            end
            if (!commit_ && empty_s) underflow <= 1'b1;
            if (pop_s && miss_s && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNTW'(1);
        end
    end

endmodule
